alu_multicycle: RTL and testbench

- Parametrised, registered successor to the pipeline's single-cycle ALU, sitting in the EX stage.
- Single-cycle ops (logic, shift, add/sub, compare) return one cycle after issue.
- MUL runs on an iterative shift-add datapath; optional unsigned DIV/REM runs on an iterative restoring divider.
- A valid/ready issue handshake lets the hazard unit stall the pipeline while a multi-cycle op is in flight.

---
 rtl/alu_multicycle.sv | 171 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered EX-stage ALU with multi-cycle multiply and an
// optional unsigned divider.
//
// Single-cycle ops (logic, shift, add/sub, compare) are registered at the
// accept edge, so valid_o pulses in the following cycle and back-to-back issue
// is allowed. MUL uses an iterative shift-add datapath that always takes XLEN
// iterations. While it runs, ready_o is low and valid_i is ignored.
//
// Optional feature: define ALU_MULTICYCLE_DIV_EN to build the restoring
// divider for DIVU (1100) and REMU (1101). Without it, those codes are
// reserved: single-cycle, result 0.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   issue handshake (accept when both are high)
//   opsrc1_i, opsrc2_i  operands A, B (XLEN)
//   control_i           4-bit operation select
//   valid_o             one-cycle completion pulse
//   result_o, zero_o    registered result and (A == B) of the completed op
//   busy_o              high while MUL/DIV iterate
module alu_multicycle #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] opsrc1_i,
    input  logic [XLEN-1:0] opsrc2_i,
    input  logic [3:0]      control_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            busy_o
);

    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t          state;
    logic [XLEN-1:0] mcand;   // multiplicand (MUL) / divisor (DIV)
    logic [XLEN-1:0] mplier;  // multiplier (MUL) / dividend->quotient (DIV)
    logic [XLEN-1:0] acc;     // product accumulator (MUL) / partial remainder (DIV)
    logic [SHW-1:0]  cnt;
    logic            zero_q;  // A == B of the op in flight, captured at accept
    logic [XLEN-1:0] mul_acc_nxt;

    assign ready_o = (state == ST_IDLE);
    assign busy_o  = (state != ST_IDLE);

    assign mul_acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_MULTICYCLE_DIV_EN
    logic            rem_sel;
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    // Restoring step: bring in the next dividend bit and subtract the divisor
    // if it fits. A zero divisor always fits, so the quotient becomes all ones
    // and the remainder ends as the dividend, without a special case.
    assign rem_sh  = {acc, mplier[XLEN-1]};
    assign div_ge  = (rem_sh >= {1'b0, mcand});
    assign rem_nxt = div_ge ? XLEN'(rem_sh - {1'b0, mcand}) : rem_sh[XLEN-1:0];
    assign quo_nxt = {mplier[XLEN-2:0], div_ge};
`endif

    function automatic logic [XLEN-1:0] alu_single(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            4'b0000: alu_single = a & b;
            4'b0001: alu_single = a ^ b;
            4'b0010: alu_single = a << sh;
            4'b0011: alu_single = a + b;
            4'b0100,
            4'b0110: alu_single = a - b;
            4'b0111: alu_single = $signed(a) >>> sh;
            4'b1000: alu_single = a | b;
            4'b1001: alu_single = a >> sh;
            4'b1010: alu_single = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1011: alu_single = {{(XLEN-1){1'b0}}, a < b};
            default: alu_single = '0;  // MUL handled elsewhere; 1100-1111 -> 0
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
            rem_sel  <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (control_i == OP_MUL) begin
                            mcand  <= opsrc1_i;
                            mplier <= opsrc2_i;
                            acc    <= '0;
                            cnt    <= '0;
                            zero_q <= (opsrc1_i == opsrc2_i);
                            state  <= ST_MUL;
                        end
`ifdef ALU_MULTICYCLE_DIV_EN
                        else if (control_i == OP_DIVU || control_i == OP_REMU) begin
                            mcand   <= opsrc2_i;
                            mplier  <= opsrc1_i;
                            acc     <= '0;
                            cnt     <= '0;
                            zero_q  <= (opsrc1_i == opsrc2_i);
                            rem_sel <= control_i[0];
                            state   <= ST_DIV;
                        end
`endif
                        else begin
                            result_o <= alu_single(control_i, opsrc1_i, opsrc2_i);
                            zero_o   <= (opsrc1_i == opsrc2_i);
                            valid_o  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    // Last iteration writes the result directly so valid_o
                    // lands XLEN+1 cycles after accept, with ready_o back up.
                    if (cnt == SHW'(XLEN-1)) begin
                        result_o <= mul_acc_nxt;
                        zero_o   <= zero_q;
                        valid_o  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
`ifdef ALU_MULTICYCLE_DIV_EN
                ST_DIV: begin
                    acc    <= rem_nxt;
                    mplier <= quo_nxt;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == SHW'(XLEN-1)) begin
                        result_o <= rem_sel ? rem_nxt : quo_nxt;
                        zero_o   <= zero_q;
                        valid_o  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboarded randomized bench for alu_multicycle (XLEN=32).
// The driver pushes the expected result, zero flag and completion cycle
// whenever an op is accepted. The monitor pops and compares on every valid_o.
module tb_alu_multicycle;
    localparam int XLEN = 32;
    localparam int LONG_LAT = XLEN + 1;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] opsrc1_i;
    logic [XLEN-1:0] opsrc2_i;
    logic [3:0]      control_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            zero_o;
    logic            busy_o;

    alu_multicycle #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .opsrc1_i(opsrc1_i), .opsrc2_i(opsrc2_i), .control_i(control_i),
        .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            zero;
        int              cyc;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the operation's definition.
    function automatic logic [XLEN-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        int unsigned sh;
        longint unsigned prod;
        sh   = b % XLEN;
        prod = longint'(a) * longint'(b);
        case (op)
            4'd0:       return a & b;
            4'd1:       return a ^ b;
            4'd2:       return a << sh;
            4'd3:       return a + b;
            4'd4, 4'd6: return a - b;
            4'd5:       return prod[XLEN-1:0];
            4'd7:       return $signed(a) >>> sh;
            4'd8:       return a | b;
            4'd9:       return a >> sh;
            4'd10:      return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd11:      return (a < b) ? 1 : 0;
`ifdef ALU_MULTICYCLE_DIV_EN
            4'd12:      return (b == 0) ? {XLEN{1'b1}} : a / b;
            4'd13:      return (b == 0) ? a : a % b;
`endif
            default:    return 0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op);
        if (op == 4'd5) return LONG_LAT;
`ifdef ALU_MULTICYCLE_DIV_EN
        if (op == 4'd12 || op == 4'd13) return LONG_LAT;
`endif
        return 1;
    endfunction

    // Called at a negedge. Holds valid_i high until ready_o, records the
    // expectation, and returns at the negedge after the accept edge with
    // valid_i still high.
    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input bit push, output int waited);
        int n;
        n = 0;
        control_i = op; opsrc1_i = a; opsrc2_i = b; valid_i = 1'b1;
        while (!ready_o && n < 100) begin
            if (busy_o !== 1'b1) check("busy_while_stalled", {31'b0, busy_o}, 1);
            @(negedge clk_i);
            n++;
        end
        waited = n;
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL ready_timeout: ready_o still 0 after %0d cycles, required 1", n);
        end
        if (push) sbq.push_back('{res: exp, zero: (a == b), cyc: cyc + latency(op)});
        @(negedge clk_i);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: valid_o=1 with result %h, required no completion", result_o);
                end else begin
                    e = sbq.pop_front();
                    check("result", result_o, e.res);
                    check("zero", {31'b0, zero_o}, {31'b0, e.zero});
                    check("latency_cycle", XLEN'(cyc), XLEN'(e.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w;
        logic [3:0] op;
        logic [XLEN-1:0] a, b;
        rst_i = 1'b1; valid_i = 1'b0; control_i = '0; opsrc1_i = '0; opsrc2_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_ready", {31'b0, ready_o}, 1);
        check("rst_valid", {31'b0, valid_o}, 0);
        check("rst_result", result_o, 0);
        check("rst_zero", {31'b0, zero_o}, 0);
        check("rst_busy", {31'b0, busy_o}, 0);

        // ADD overflow wraps; ready stays high
        issue(4'b0011, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, w);
        check("add_ready_kept", {31'b0, ready_o}, 1);
        // back-to-back SRA then SLTU
        issue(4'b0111, 32'h8000_0000, 32'h24, 32'hF800_0000, 1, w);
        issue(4'b1011, 32'h1, 32'hFFFF_FFFF, 32'h1, 1, w);
        // MUL with an ADD held on valid_i behind it
        issue(4'b0101, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 1, w);
        check("mul_busy", {31'b0, busy_o}, 1);
        issue(4'b0011, 32'h2, 32'h3, 32'h5, 1, w);
        check("mul_stall_cycles", XLEN'(w), XLEN);
        // SUB compare equal, reserved code
        issue(4'b0110, 32'h1234, 32'h1234, 32'h0, 1, w);
        issue(4'b1110, 32'hDEAD, 32'hBEEF, 32'h0, 1, w);
`ifdef ALU_MULTICYCLE_DIV_EN
        issue(4'b1100, 32'd100, 32'd7, 32'd14, 1, w);
        issue(4'b1101, 32'd100, 32'd7, 32'd2, 1, w);
        issue(4'b1100, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, w);
        issue(4'b1101, 32'd9, 32'd0, 32'd9, 1, w);
`else
        issue(4'b1100, 32'd100, 32'd7, 32'd0, 1, w);
        check("divu_disabled_ready", {31'b0, ready_o}, 1);
`endif
        valid_i = 1'b0;
        repeat (40) @(negedge clk_i);

        // reset in the middle of a MUL: no completion may follow
        issue(4'b0101, 32'd5, 32'd7, 32'd35, 0, w);
        valid_i = 1'b0;
        repeat (8) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_ready", {31'b0, ready_o}, 1);
        check("midrst_valid", {31'b0, valid_o}, 0);
        check("midrst_result", result_o, 0);
        check("midrst_busy", {31'b0, busy_o}, 0);
        repeat (40) @(negedge clk_i);
        issue(4'b0001, 32'd5, 32'd7, 32'h2, 1, w);

        // randomized traffic with corner-biased operands
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = a;
                1: b = 0;
                2: b = $urandom_range(0, 40);
                3: a = $urandom_range(0, 300);
                default: ;
            endcase
            issue(op, a, b, model(op, a, b), 1, w);
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                @(negedge clk_i);
            end
        end

        valid_i = 1'b0;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk_i);
        check("scoreboard_drained", XLEN'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
